// File: rtl/snd_reg_arb.sv
// snd_reg_arb: merges CPU sound-register writes and save-state restore writes
// onto one register-bank write port. Optional: SND_ARB_READBACK_EN (shadow bank).
module snd_reg_arb (
  input  logic        cpu_m2,
  input  logic        rst,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        sst_act,
  input  logic        sst_valid,
  output logic        sst_ready,
  input  logic [3:0]  sst_idx,
  input  logic [7:0]  sst_data,
  output logic        wr_en,
  output logic [3:0]  wr_idx,
  output logic [7:0]  wr_data,
  output logic        snd_halt,
  output logic        idx_err,
  input  logic [3:0]  rb_idx,
  output logic [7:0]  rb_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESTORE,
    ST_DRAIN,
    ST_SETTLE
  } state_t;

  localparam logic [2:0] FULL = 3'd4;
  localparam logic [3:0] LAST = 4'd9;

  // cpu decode
  logic       cpu_map;
  logic [3:0] cpu_idx;

  // fifo
  logic [3:0] mem_idx_q [4];
  logic [7:0] mem_dat_q [4];
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] cnt_q, cnt_d;

  // arbitration
  logic cpu_hit;
  logic sst_acc;
  logic sst_bad;
  logic push;
  logic pop;

  // write port
  logic       wr_en_q, wr_en_d;
  logic [3:0] wr_idx_q, wr_idx_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       err_q, err_d;

  // halt sequencer
  state_t state_q;
  logic   settle_q;
  logic   halt_q;

  // Map the three register windows onto logical indices 0..9
  always_comb begin
    cpu_map = 1'b0;
    cpu_idx = 4'd0;
    if (cpu_addr[11:2] == 10'd0) begin
      case (cpu_addr[15:12])
        4'h9: begin
          cpu_map = 1'b1;
          cpu_idx = {2'b00, cpu_addr[1:0]};
        end
        4'hA: begin
          if (cpu_addr[1:0] != 2'b11) begin
            cpu_map = 1'b1;
            cpu_idx = 4'd4 + {2'b00, cpu_addr[1:0]};
          end
        end
        4'hB: begin
          if (cpu_addr[1:0] != 2'b11) begin
            cpu_map = 1'b1;
            cpu_idx = 4'd7 + {2'b00, cpu_addr[1:0]};
          end
        end
        default: begin
          cpu_map = 1'b0;
          cpu_idx = 4'd0;
        end
      endcase
    end
  end

  // Ready is judged on the count held at the start of the cycle only
  assign sst_ready = (cnt_q != FULL);
  assign sst_acc   = sst_valid & sst_ready;
  assign sst_bad   = (sst_idx > LAST);
  assign push      = sst_acc & ~sst_bad;
  assign cpu_hit   = cpu_we & cpu_map;
  assign pop       = ~cpu_hit & (cnt_q != 3'd0);

  // Queue pointer and occupancy next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // CPU write wins the port; otherwise the queue head goes out
  always_comb begin
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    if (cpu_hit) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = cpu_idx;
      wr_data_d = cpu_data;
    end else if (pop) begin
      wr_en_d   = 1'b1;
      wr_idx_d  = mem_idx_q[rd_ptr_q];
      wr_data_d = mem_dat_q[rd_ptr_q];
    end
  end

  // Bad restore indices latch the error flag until reset
  always_comb begin
    err_d = err_q | (sst_acc & sst_bad);
  end

  // Queue storage; contents are don't-care while the slot is empty
  always_ff @(negedge cpu_m2) begin
    if (push) begin
      mem_idx_q[wr_ptr_q] <= sst_idx;
      mem_dat_q[wr_ptr_q] <= sst_data;
    end
  end

  // Queue control registers
  always_ff @(negedge cpu_m2) begin
    if (rst) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Registered write port and error flag
  always_ff @(negedge cpu_m2) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_idx_q  <= 4'd0;
      wr_data_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // Halt sequencer: hold tones frozen through restore, drain and settle
  always_ff @(negedge cpu_m2) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (sst_act) begin
            state_q <= ST_RESTORE;
            halt_q  <= 1'b1;
          end
        end
        ST_RESTORE: begin
          if (!sst_act) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (sst_act) begin
            state_q <= ST_RESTORE;
          end else if (cnt_q == 3'd0) begin
            state_q  <= ST_SETTLE;
            settle_q <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (sst_act) begin
            state_q <= ST_RESTORE;
          end else if (settle_q) begin
            state_q <= ST_IDLE;
            halt_q  <= 1'b0;
          end else begin
            settle_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_idx   = wr_idx_q;
  assign wr_data  = wr_data_q;
  assign snd_halt = halt_q;
  assign idx_err  = err_q;

`ifdef SND_ARB_READBACK_EN
  logic [7:0] shadow_q [10];

  // Shadow copy follows every issued register write
  always_ff @(negedge cpu_m2) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) begin
        shadow_q[i] <= 8'd0;
      end
    end else if (wr_en_q && (wr_idx_q <= LAST)) begin
      shadow_q[wr_idx_q] <= wr_data_q;
    end
  end

  // Readback of the shadow bank; unmapped indices read as all ones
  always_comb begin
    rb_data = 8'hFF;
    if (rb_idx <= LAST) begin
      rb_data = shadow_q[rb_idx];
    end
  end
`else
  logic unused_rb;

  assign unused_rb = ^rb_idx;
  assign rb_data   = 8'hFF;
`endif

endmodule

// File: tb/tb_snd_reg_arb.sv
// tb_snd_reg_arb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_snd_reg_arb;

  logic        cpu_m2 = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data = 8'h00;
  logic        sst_act = 1'b0;
  logic        sst_valid = 1'b0;
  logic        sst_ready;
  logic [3:0]  sst_idx = 4'd0;
  logic [7:0]  sst_data = 8'h00;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [7:0]  wr_data;
  logic        snd_halt;
  logic        idx_err;
  logic [3:0]  rb_idx = 4'd0;
  logic [7:0]  rb_data;

  int n_pass = 0;
  int n_tot  = 0;
  bit chk_on = 1'b0;

  snd_reg_arb dut (
    .cpu_m2(cpu_m2), .rst(rst), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .sst_act(sst_act), .sst_valid(sst_valid),
    .sst_ready(sst_ready), .sst_idx(sst_idx),
    .sst_data(sst_data), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .snd_halt(snd_halt),
    .idx_err(idx_err), .rb_idx(rb_idx), .rb_data(rb_data)
  );

  always #5 cpu_m2 = ~cpu_m2;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge cpu_m2);
    #1;
  endtask

  function automatic int map_addr(input logic [15:0] a);
    if (a >= 16'h9000 && a <= 16'h9003) return int'(a - 16'h9000);
    if (a >= 16'hA000 && a <= 16'hA002) return 4 + int'(a - 16'hA000);
    if (a >= 16'hB000 && a <= 16'hB002) return 7 + int'(a - 16'hB000);
    return -1;
  endfunction

  // reference model: queue of pending restore writes, halt phase by rules
  typedef struct packed { logic [3:0] idx; logic [7:0] dat; } ent_t;
  ent_t       mq[$];
  logic       m_en;
  logic [3:0] m_idx;
  logic [7:0] m_dat;
  logic       m_err;
  int         m_ph;   // 0 idle, 1 restore, 2 drain, 3 settle
  int         m_left;
  logic [7:0] m_sh [10];
  int         m_sz;
  int         m_mi;
  ent_t       m_h;

  always @(negedge cpu_m2) begin
    if (rst) begin
      mq.delete();
      m_en = 0; m_idx = 0; m_dat = 0; m_err = 0;
      m_ph = 0; m_left = 0;
      for (int i = 0; i < 10; i++) m_sh[i] = 8'h00;
    end else begin
      m_sz = mq.size();
      m_mi = map_addr(cpu_addr);
      if (m_en) m_sh[m_idx] = m_dat;
      if (cpu_we && m_mi >= 0) begin
        m_en = 1; m_idx = 4'(m_mi); m_dat = cpu_data;
      end else if (m_sz > 0) begin
        m_h = mq.pop_front();
        m_en = 1; m_idx = m_h.idx; m_dat = m_h.dat;
      end else begin
        m_en = 0;
      end
      if (sst_valid && m_sz < 4) begin
        if (sst_idx > 9) m_err = 1;
        else mq.push_back({sst_idx, sst_data});
      end
      case (m_ph)
        0: if (sst_act) m_ph = 1;
        1: if (!sst_act) m_ph = 2;
        2: if (sst_act) m_ph = 1;
           else if (m_sz == 0) begin m_ph = 3; m_left = 2; end
        default: if (sst_act) m_ph = 1;
           else begin
             m_left--;
             if (m_left == 0) m_ph = 0;
           end
      endcase
    end
  end

  function automatic logic [7:0] m_rb(input logic [3:0] i);
`ifdef SND_ARB_READBACK_EN
    if (i > 9) return 8'hFF;
    return m_sh[i];
`else
    return 8'hFF;
`endif
  endfunction

  // per-cycle comparison against the model
  always @(posedge cpu_m2) begin
    if (chk_on) begin
      chk("m_wr_en", {7'd0, wr_en}, {7'd0, m_en});
      chk("m_wr_idx", {4'd0, wr_idx}, {4'd0, m_idx});
      chk("m_wr_data", wr_data, m_dat);
      chk("m_ready", {7'd0, sst_ready}, {7'd0, (mq.size() < 4)});
      chk("m_halt", {7'd0, snd_halt}, {7'd0, (m_ph != 0)});
      chk("m_err", {7'd0, idx_err}, {7'd0, m_err});
      chk("m_rb", rb_data, m_rb(rb_idx));
    end
  end

  logic [3:0]  got_i[$];
  logic [7:0]  got_d[$];
  logic [15:0] at [8];
  logic [3:0]  ei [5];
  logic [7:0]  ed [5];
  bit          acc;
  bit          seen;
  logic [7:0]  hb [6];

  initial begin
    at = '{16'h9000, 16'h9003, 16'h9004, 16'hA000,
           16'hA002, 16'hA003, 16'hB002, 16'hC000};
    ei = '{4'd1, 4'd1, 4'd1, 4'd6, 4'd7};
    ed = '{8'hC0, 8'hC1, 8'hC2, 8'h60, 8'h61};
    hb = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0};

    // reset state
    tick(); tick();
    rst = 0;
    chk_on = 1;
    chk("rst_wr_en", {7'd0, wr_en}, 8'd0);
    chk("rst_wr_idx", {4'd0, wr_idx}, 8'd0);
    chk("rst_wr_data", wr_data, 8'd0);
    chk("rst_halt", {7'd0, snd_halt}, 8'd0);
    chk("rst_err", {7'd0, idx_err}, 8'd0);
    chk("rst_ready", {7'd0, sst_ready}, 8'd1);

    // CPU write mapped / unmapped
    cpu_we = 1; cpu_addr = 16'hA001; cpu_data = 8'h5A;
    tick();
    cpu_we = 0;
    chk("a_wr_en", {7'd0, wr_en}, 8'd1);
    chk("a_wr_idx", {4'd0, wr_idx}, 8'd5);
    chk("a_wr_data", wr_data, 8'h5A);
    cpu_we = 1; cpu_addr = 16'hA003; cpu_data = 8'h77;
    tick();
    cpu_we = 0;
    chk("a_unmapped", {7'd0, wr_en}, 8'd0);

    // restore burst of 5 against a full queue
    sst_act = 1;
    tick();
    chk("b_halt_on", {7'd0, snd_halt}, 8'd1);
    cpu_we = 1; cpu_addr = 16'h9000;
    for (int i = 0; i < 4; i++) begin
      chk("b_ready", {7'd0, sst_ready}, 8'd1);
      sst_valid = 1; sst_idx = 4'(i); sst_data = 8'h10 + 8'(i);
      cpu_data = 8'(i);
      tick();
    end
    sst_idx = 4'd4; sst_data = 8'h14;
    chk("b_full", {7'd0, sst_ready}, 8'd0);
    cpu_we = 0;
    got_i.delete(); got_d.delete();
    for (int k = 0; k < 12; k++) begin
      acc = sst_valid && sst_ready;
      tick();
      if (acc) sst_valid = 0;
      if (wr_en) begin got_i.push_back(wr_idx); got_d.push_back(wr_data); end
    end
    chk("b_halt_hold", {7'd0, snd_halt}, 8'd1);
    chk("b_count", 8'(got_i.size()), 8'd5);
    for (int j = 0; j < 5; j++)
      if (j < got_i.size()) begin
        chk("b_order", {4'd0, got_i[j]}, 8'(j));
        chk("b_data", got_d[j], 8'h10 + 8'(j));
      end

    // CPU writes take priority over two queued entries
    cpu_we = 1; cpu_addr = 16'h9001; cpu_data = 8'hC0;
    sst_valid = 1; sst_idx = 4'd6; sst_data = 8'h60;
    got_i.delete(); got_d.delete();
    for (int k = 0; k < 5; k++) begin
      tick();
      got_i.push_back(wr_idx); got_d.push_back(wr_data);
      chk("c_wr_en", {7'd0, wr_en}, 8'd1);
      if (k == 0) begin cpu_data = 8'hC1; sst_idx = 4'd7; sst_data = 8'h61; end
      if (k == 1) begin cpu_data = 8'hC2; sst_valid = 0; end
      if (k == 2) cpu_we = 0;
    end
    for (int j = 0; j < 5; j++) begin
      chk("c_idx", {4'd0, got_i[j]}, {4'd0, ei[j]});
      chk("c_data", got_d[j], ed[j]);
    end
    tick();
    chk("c_idle", {7'd0, wr_en}, 8'd0);

    // drain three entries, then settle
    cpu_we = 1; cpu_addr = 16'hB001; sst_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sst_idx = 4'(i); sst_data = 8'hD0 + 8'(i); cpu_data = 8'(i);
      tick();
    end
    sst_valid = 0; cpu_we = 0; sst_act = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("d_halt_seq", {7'd0, snd_halt}, hb[k]);
    end
    sst_act = 1; tick();
    sst_act = 0; tick();
    tick();
    sst_act = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("d_reenter", {7'd0, snd_halt}, 8'd1);
    end
    sst_act = 0;
    tick(); tick(); tick();
    chk("d_settle2", {7'd0, snd_halt}, 8'd1);
    tick();
    chk("d_release", {7'd0, snd_halt}, 8'd0);

    // invalid restore index
    sst_valid = 1; sst_idx = 4'd12; sst_data = 8'h99;
    tick();
    sst_valid = 0;
    chk("e_no_wr", {7'd0, wr_en}, 8'd0);
    chk("e_err", {7'd0, idx_err}, 8'd1);
    tick(); tick(); tick();
    chk("e_sticky", {7'd0, idx_err}, 8'd1);

    // reset mid-restore discards the queue
    sst_act = 1; cpu_we = 1; cpu_addr = 16'h9002; sst_valid = 1;
    for (int i = 0; i < 3; i++) begin
      sst_idx = 4'(i + 1); sst_data = 8'hE0 + 8'(i);
      tick();
    end
    rst = 1; cpu_we = 0; sst_valid = 0; sst_act = 0;
    tick();
    rst = 0;
    chk("r_ready", {7'd0, sst_ready}, 8'd1);
    chk("r_err", {7'd0, idx_err}, 8'd0);
    chk("r_halt", {7'd0, snd_halt}, 8'd0);
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (wr_en) seen = 1;
      tick();
    end
    chk("r_no_wr", {7'd0, seen}, 8'd0);

    // readback
    cpu_we = 1; cpu_addr = 16'hB002; cpu_data = 8'hC3;
    tick();
    cpu_we = 0;
    tick();
    rb_idx = 4'd9; #1;
`ifdef SND_ARB_READBACK_EN
    chk("rb_9", rb_data, 8'hC3);
    rb_idx = 4'd11; #1;
    chk("rb_11", rb_data, 8'hFF);
    rst = 1; tick(); rst = 0;
    rb_idx = 4'd9; #1;
    chk("rb_rst", rb_data, 8'h00);
`else
    chk("rb_tied", rb_data, 8'hFF);
    rb_idx = 4'd2; #1;
    chk("rb_tied2", rb_data, 8'hFF);
`endif

    // table-driven mixed traffic, model-checked every cycle
    for (int k = 0; k < 160; k++) begin
      cpu_we    = (k % 4) != 1 && (k % 7) != 3;
      cpu_addr  = at[k % 8];
      cpu_data  = 8'(k * 7);
      sst_valid = (k % 3) != 0;
      sst_idx   = 4'((k * 5) % 13);
      sst_data  = 8'(k);
      sst_act   = (k % 40) < 15;
      rb_idx    = 4'(k % 12);
      tick();
    end
    cpu_we = 0; sst_valid = 0; sst_act = 0;
    for (int k = 0; k < 12; k++) tick();
    chk("z_quiet_halt", {7'd0, snd_halt}, 8'd0);
    chk("z_quiet_ready", {7'd0, sst_ready}, 8'd1);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/snd_reg_arb.md
SND_REG_ARB -- requirements
Module: snd_reg_arb

Interface
REQ-001 SHALL have a single clock and synchronous, active-high reset; all state updates on the falling edge of cpu_m2.
REQ-002 cpu_m2  in  1  system clock (CPU M2).
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 cpu_we  in  1  CPU write strobe, already qualified by !cpu_rw.
REQ-005 cpu_addr  in  16  CPU address.
REQ-006 cpu_data  in  8  CPU write data.
REQ-007 sst_act  in  1  save-state restore session active.
REQ-008 sst_valid  in  1  restore write offered.
REQ-009 sst_ready  out  1  restore write accepted this cycle when high with sst_valid.
REQ-010 sst_idx  in  4  logical register index of restore write.
REQ-011 sst_data  in  8  restore write data.
REQ-012 wr_en  out  1  register-bank write strobe, one cycle.
REQ-013 wr_idx  out  4  logical register index.
REQ-014 wr_data  out  8  register data.
REQ-015 snd_halt  out  1  freezes all tone generators.
REQ-016 idx_err  out  1  sticky invalid-index flag.
REQ-017 rb_idx  in  4  readback index.
REQ-018 rb_data  out  8  readback data (combinational).

Function
REQ-019 Logical index map SHALL be: 0..3 = $9000..$9003, 4..6 = $A000..$A002, 7..9 = $B000..$B002; indices 10..15 are invalid.
REQ-020 A cpu_we cycle at a mapped address SHALL produce wr_en=1 with the mapped index and cpu_data on the next cycle (latency 1); unmapped CPU addresses are ignored silently.
REQ-021 Restore writes SHALL pass through a 4-entry FIFO; sst_ready = FIFO not full, evaluated from the count at the start of the cycle.
REQ-022 An accepted restore write with sst_idx > 9 SHALL NOT be pushed, and SHALL set idx_err.
REQ-023 Arbitration: at most one wr_en per cycle; a mapped CPU write always wins; the FIFO head pops only in cycles without a mapped CPU write.
REQ-024 Popped entry SHALL appear on wr_en/wr_idx/wr_data the following cycle; FIFO order is preserved.
REQ-025 Simultaneous push and pop SHALL leave the count unchanged; pop when empty and push when full SHALL never occur.
REQ-026 Halt FSM states: IDLE (halt=0), RESTORE (halt=1), DRAIN (halt=1), SETTLE (halt=1, 2 cycles).
REQ-027 Transitions: IDLE->RESTORE on sst_act=1; RESTORE->DRAIN on sst_act=0; DRAIN->SETTLE when the FIFO is empty and no pop is pending; SETTLE->IDLE after 2 cycles.
REQ-028 sst_act=1 in DRAIN or SETTLE SHALL return the FSM to RESTORE.
REQ-029 snd_halt SHALL be a registered output of the FSM state.
REQ-030 CPU writes SHALL be honoured in every FSM state.

Reset
REQ-031 rst SHALL set: FIFO empty, FSM IDLE, wr_en=0, wr_idx=0, wr_data=0, snd_halt=0, idx_err=0, and shadow registers (if present) = 0.
REQ-032 rst mid-restore SHALL discard FIFO contents without issuing wr_en; sst_ready=1 in the first cycle after reset.
REQ-033 idx_err SHALL clear only on rst.

Configuration
REQ-034 Macro SND_ARB_READBACK_EN defined: a 10x8 shadow bank is updated on every wr_en; rb_data = shadow[rb_idx], or 8'hFF for rb_idx > 9.
REQ-035 Macro SND_ARB_READBACK_EN undefined: no shadow storage; rb_data is tied to 8'hFF.

Verification
REQ-036 CPU write $A001=8'h5A -> next cycle wr_en=1, wr_idx=5, wr_data=8'h5A; $A003 write -> no wr_en.
REQ-037 sst_act=1; 5 back-to-back valid writes, idx 0..4 -> sst_ready=0 after 4 are accepted; all 5 emerge in order; snd_halt=1 throughout.
REQ-038 FIFO holds 2 entries while cpu_we is held for 3 cycles -> 3 CPU writes are issued first, then the 2 FIFO entries; never 2 wr_en in one cycle.
REQ-039 sst_idx=12 accepted -> no wr_en, idx_err=1 and stays 1 until rst.
REQ-040 Drop sst_act with 3 entries queued -> DRAIN until empty, then snd_halt stays 1 for 2 more cycles, then 0; re-assert sst_act during SETTLE -> back to RESTORE.
REQ-041 With SND_ARB_READBACK_EN: write idx 9=8'hC3, then rb_idx=9 -> rb_data=8'hC3; rb_idx=11 -> 8'hFF; after rst -> rb_data for idx 9 = 0.
